// File: rtl/exp_avg_pkg.sv
// Purpose: shared FSM state encoding and default datapath constants for exp_avg_scheduler.
// Latency: n/a; holds types and constants only.
// Backpressure: n/a.
package exp_avg_pkg;

  localparam int DEF_DATA_W      = 16;
  localparam int DEF_ALPHA_SHIFT = 3;

  // Encoding 2'd3 is unused; the scheduler treats it as illegal and returns to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/exp_avg_scheduler_rr_arbiter.sv
// Purpose: round-robin picker. Search starts at the channel after last_grant_i.
// Latency: purely combinational.
// Backpressure: none. The caller decides whether a grant is consumed.
// Ports: req_i (request vector), last_grant_i (last accepted channel),
//        grant_o (one-hot or zero), idx_o (index of grant_o, 0 when no request).
module rr_arbiter
  import exp_avg_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  last_grant_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  idx_o
);

  // Walk the offsets from farthest to nearest. The nearest requester is written
  // last, so it wins without needing a separate "found" flag.
  always_comb begin
    logic [IDX_W-1:0] cand;
    cand    = '0;
    grant_o = '0;
    idx_o   = '0;
    for (int off = NUM_CH; off >= 1; off--) begin
      cand = IDX_W'((int'(last_grant_i) + off) % NUM_CH);
      if (req_i[cand]) begin
        grant_o       = '0;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/exp_avg_scheduler.sv
// Purpose: shared exponential averager, y += (x - y) >>> ALPHA_SHIFT, time-multiplexed over NUM_CH channels.
// Latency: handshake in cycle N gives out_valid in cycle N+2; one result every 3 cycles at best.
// Backpressure: OUT holds its result until out_ready. No request is accepted outside IDLE.
// Ports: clk, reset_n (async, active low); req_valid/req_data/req_ready are the per-channel sample inputs;
//        out_valid/out_ready/out_ch/out_data form the result stream.
// Optional macro EXP_AVG_SCHED_CLEAR_EN adds input ch_clear, which zeroes the state of the selected channels.
module exp_avg_scheduler
  import exp_avg_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int ALPHA_SHIFT = DEF_ALPHA_SHIFT,
  localparam int CH_W       = $clog2(NUM_CH)
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_CH-1:0]              req_valid,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  req_data,
  output logic [NUM_CH-1:0]              req_ready,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CH_W-1:0]                out_ch,
  output logic signed [DATA_W-1:0]       out_data
`ifdef EXP_AVG_SCHED_CLEAR_EN
  ,
  input  logic [NUM_CH-1:0]              ch_clear
`endif
);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     last_grant_q, last_grant_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   x_q, x_d;
  logic                out_valid_q, out_valid_d;
  logic [CH_W-1:0]     out_ch_q, out_ch_d;
  logic [DATA_W-1:0]   out_data_q, out_data_d;
  logic [DATA_W-1:0]   y_q [NUM_CH];
  logic [DATA_W-1:0]   y_d [NUM_CH];

  logic [NUM_CH-1:0]   grant;
  logic [CH_W-1:0]     grant_idx;

  rr_arbiter #(
    .NUM_CH (NUM_CH),
    .IDX_W  (CH_W)
  ) u_arb (
    .req_i        (req_valid),
    .last_grant_i (last_grant_q),
    .grant_o      (grant),
    .idx_o        (grant_idx)
  );

  // Datapath. diff is one bit wider than the samples so that x - y cannot wrap.
  // y_new always lies between y and x, so truncating the sum to DATA_W bits is exact.
  logic signed [DATA_W-1:0] y_cur;
  logic signed [DATA_W:0]   diff, step, sum;
  logic [DATA_W-1:0]        y_new;
  logic                     unused_sum_msb;

  assign y_cur          = y_q[ch_q];
  assign diff           = {x_q[DATA_W-1], x_q} - {y_cur[DATA_W-1], y_cur};
  assign step           = diff >>> ALPHA_SHIFT;
  assign sum            = {y_cur[DATA_W-1], y_cur} + step;
  assign y_new          = sum[DATA_W-1:0];
  assign unused_sum_msb = sum[DATA_W];

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    ch_d         = ch_q;
    x_d          = x_q;
    out_valid_d  = out_valid_q;
    out_ch_d     = out_ch_q;
    out_data_d   = out_data_q;
    y_d          = y_q;
    req_ready    = '0;

    case (state_q)
      IDLE: begin
        req_ready = grant;
        if (|req_valid) begin
          last_grant_d = grant_idx;
          ch_d         = grant_idx;
          x_d          = req_data[grant_idx];
          state_d      = CALC;
        end
      end
      CALC: begin
        y_d[ch_q]   = y_new;
        out_valid_d = 1'b1;
        out_ch_d    = ch_q;
        out_data_d  = y_new;
        state_d     = OUT;
      end
      OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase

`ifdef EXP_AVG_SCHED_CLEAR_EN
    // A clear takes priority over a same-cycle CALC write. out_data_d still carries y_new.
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_clear[i]) y_d[i] = '0;
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_grant_q <= CH_W'(NUM_CH - 1);
      ch_q         <= '0;
      x_q          <= '0;
      out_valid_q  <= 1'b0;
      out_ch_q     <= '0;
      out_data_q   <= '0;
      for (int i = 0; i < NUM_CH; i++) y_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      ch_q         <= ch_d;
      x_q          <= x_d;
      out_valid_q  <= out_valid_d;
      out_ch_q     <= out_ch_d;
      out_data_q   <= out_data_d;
      y_q          <= y_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_exp_avg_scheduler.sv
`timescale 1ns/1ps
module tb_exp_avg_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int K   = 3;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NCH-1:0]            req_valid;
  logic [NCH-1:0][DW-1:0]    req_data;
  logic [NCH-1:0]            req_ready;
  logic                      out_valid;
  logic                      out_ready;
  logic [1:0]                out_ch;
  logic signed [DW-1:0]      out_data;
`ifdef EXP_AVG_SCHED_CLEAR_EN
  logic [NCH-1:0]            ch_clear;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  exp_avg_scheduler #(.NUM_CH(NCH), .DATA_W(DW), .ALPHA_SHIFT(K)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch),
    .out_data  (out_data)
`ifdef EXP_AVG_SCHED_CLEAR_EN
    ,
    .ch_clear  (ch_clear)
`endif
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_avg [NCH];
  int m_last;
  bit m_busy;
  int m_cnt;
  int m_exp_ch;
  int m_exp_data;

  // alpha = 2^-K, with the correction rounded toward minus infinity.
  function automatic int ema(input int y, input int x);
    int d;
    int s;
    d = x - y;
    if (d >= 0) s = d / (1 << K);
    else        s = -((-d + (1 << K) - 1) / (1 << K));
    return y + s;
  endfunction

  function automatic int rr_pick(input logic [NCH-1:0] v, input int last);
    logic [1:0] c;
    for (int off = 1; off <= NCH; off++) begin
      c = 2'((last + off) % NCH);
      if (v[c]) return int'(c);
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) m_avg[i] = 0;
    m_last = NCH - 1;
    m_busy = 0;
    m_cnt  = 0;
  endtask

  // Compare process: inputs change just after posedge, so the negedge sees stable values.
  always @(negedge clk) begin
    if (!reset_n) begin
      check("rst_out_valid", int'(out_valid), 0);
      check("rst_out_ch", int'(out_ch), 0);
      check("rst_out_data", int'(out_data), 0);
      model_reset();
    end else begin
      if (m_busy) begin
        check("busy_req_ready", int'(req_ready), 0);
        if (m_cnt < 2) begin
          check("calc_out_valid", int'(out_valid), 0);
          m_cnt++;
        end else begin
          check("out_valid", int'(out_valid), 1);
          check("out_ch", int'(out_ch), m_exp_ch);
          check("out_data", int'(out_data), m_exp_data);
          if (out_ready) m_busy = 0;
        end
      end else begin
        int w;
        logic [1:0] wi;
        w = rr_pick(req_valid, m_last);
        check("idle_out_valid", int'(out_valid), 0);
        check("req_ready", int'(req_ready), (w < 0) ? 0 : (1 << w));
        if (w >= 0) begin
          wi         = 2'(w);
          m_last     = w;
          m_avg[w]   = ema(m_avg[w], int'($signed(req_data[wi])));
          m_exp_ch   = w;
          m_exp_data = m_avg[w];
          m_busy     = 1;
          m_cnt      = 1;
        end
      end
`ifdef EXP_AVG_SCHED_CLEAR_EN
      for (int i = 0; i < NCH; i++) if (ch_clear[i]) m_avg[i] = 0;
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  task automatic drain();
    req_valid = '0;
    out_ready = 1'b1;
    repeat (4) tick();
  endtask

  task automatic wait_grant(input logic [1:0] ch);
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = req_ready[ch];
    end
    check("grant_seen", int'(got), 1);
  endtask

  task automatic wait_valid();
    bit got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      @(negedge clk);
      got = out_valid;
    end
    check("valid_seen", int'(got), 1);
  endtask

  // One sample on one channel, with out_ready high. Checks the result against a literal value.
  task automatic send(input logic [1:0] ch, input int x, input int exp);
    req_valid     = '0;
    req_valid[ch] = 1'b1;
    req_data[ch]  = DW'(x);
    wait_grant(ch);
    @(posedge clk);
    #1 req_valid = '0;
    wait_valid();
    check("send_ch", int'(out_ch), int'(ch));
    check("send_data", int'(out_data), exp);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset_n   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    out_ready = 1'b1;
`ifdef EXP_AVG_SCHED_CLEAR_EN
    ch_clear  = '0;
`endif
    tick();
    tick();
    reset_n = 1'b1;
    tick();

    // Step response and floor rounding.
    send(2'd0, 16000, 2000);
    send(2'd0, 16000, 3750);
    send(2'd1, -1, -1);
    send(2'd2, -8000, -1000);

    // Fairness: all channels request continuously.
    do_reset();
    begin
      int order[$];
      int times[$];
      for (int i = 0; i < NCH; i++) req_data[i] = DW'($urandom);
      req_valid = '1;
      for (int cyc = 0; cyc < 40 && order.size() < 6; cyc++) begin
        @(negedge clk);
        for (int i = 0; i < NCH; i++) begin
          if (req_ready[i]) begin
            order.push_back(i);
            times.push_back(cyc);
          end
        end
      end
      @(posedge clk);
      #1 req_valid = '0;
      check("fair_count", order.size(), 6);
      for (int i = 0; i < order.size(); i++) begin
        check("fair_order", order[i], i % NCH);
        if (i > 0) check("fair_gap", times[i] - times[i-1], 3);
      end
    end
    drain();

    // Backpressure: hold the result in OUT while the other channels keep requesting.
    begin
      int v_ch;
      int v_data;
      req_valid = 4'b1000;
      req_data[3] = DW'(1234);
      out_ready = 1'b0;
      wait_grant(2'd3);
      @(posedge clk);
      #1 req_valid = '1;
      wait_valid();
      v_ch   = int'(out_ch);
      v_data = int'(out_data);
      check("bp_ch", v_ch, 3);
      for (int i = 0; i < 5; i++) begin
        check("bp_valid_hold", int'(out_valid), 1);
        check("bp_ch_hold", int'(out_ch), v_ch);
        check("bp_data_hold", int'(out_data), v_data);
        check("bp_req_ready", int'(req_ready), 0);
        @(negedge clk);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      @(negedge clk);
      check("bp_valid_at_rise", int'(out_valid), 1);
      @(negedge clk);
      check("bp_released", int'(out_valid), 0);
      check("bp_next_grant", int'(req_ready), 1);
    end
    drain();

    // Reset during CALC: the pending result is discarded and the state is cleared.
    send(2'd0, 5000, ema(m_avg[0], 5000));
    req_valid    = 4'b0001;
    req_data[0]  = DW'(5000);
    wait_grant(2'd0);
    @(posedge clk);
    #1 req_valid = '0;
    reset_n = 1'b0;
    #1;
    check("rst_calc_valid", int'(out_valid), 0);
    tick();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("no_stale_result", int'(out_valid), 0);
    end
    tick();
    send(2'd0, 800, 100);

    // Reset while a result is presented in OUT.
    out_ready    = 1'b0;
    req_valid    = 4'b0010;
    req_data[1]  = DW'(4000);
    wait_grant(2'd1);
    @(posedge clk);
    #1 req_valid = '0;
    wait_valid();
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_drop_valid", int'(out_valid), 0);
    check("rst_out_drop_data", int'(out_data), 0);
    tick();
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    send(2'd1, 4000, 500);

`ifdef EXP_AVG_SCHED_CLEAR_EN
    do_reset();
    send(2'd0, 16000, 2000);
    send(2'd0, 16000, 3750);
    ch_clear = 4'b0001;
    tick();
    ch_clear = '0;
    send(2'd0, 16000, 2000);
    // Clear that lands on the CALC write of the same channel.
    req_valid   = 4'b0100;
    req_data[2] = DW'(16000);
    wait_grant(2'd2);
    @(posedge clk);
    #1 req_valid = '0;
    ch_clear = 4'b0100;
    tick();
    ch_clear = '0;
    wait_valid();
    check("clr_calc_out", int'(out_data), 2000);
    tick();
    send(2'd2, 16000, 2000);
`endif

    // Randomized traffic checked by the model.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req_valid = NCH'($urandom);
      for (int i = 0; i < NCH; i++) req_data[i] = DW'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
